logic_unit_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit; successor to the fixed 32-bit combinational XOR.
- Supports eight bitwise ops selected per transaction, configurable datapath width and pipeline depth, valid/ready handshakes on both sides, and a zero flag.
- Sits in the execute stage of the RISC-V core, between operand issue and writeback arbitration.

---
 rtl/logic_unit_pkg.sv | 29 ++
 rtl/logic_unit_pipe_stage.sv | 26 ++
 rtl/logic_unit_pipe.sv | 53 +++++
 tb/tb_logic_unit_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared op encodings and the per-bit logic function for the pipelined logic unit.
package logic_unit_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd3;
  localparam logic [OP_W-1:0] OP_ANDN = 3'd4;
  localparam logic [OP_W-1:0] OP_ORN  = 3'd5;
  localparam logic [OP_W-1:0] OP_NAND = 3'd6;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd7;

  // Single-bit form so any datapath width can apply it lane by lane.
  function automatic logic logic_op(input logic a, input logic b, input logic [OP_W-1:0] op);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_ANDN: r = a & ~b;
      OP_ORN:  r = a | ~b;
      OP_NAND: r = ~(a & b);
      default: r = ~(a | b);
    endcase
    return r;
  endfunction
endpackage

// File: rtl/logic_unit_pipe_stage.sv
// One valid/ready register slice; an empty slot accepts even when downstream stalls.
module pipe_stage #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);
  // Reset forces ready so the unit advertises acceptance while being cleared.
  assign up_ready = rst || !dn_valid || dn_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) dn_data <= up_data;
    end
  end
endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: eight ops, zero flag, STAGES-deep valid/ready pipeline.
module logic_unit_pipe import logic_unit_pkg::*; #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero
);
  if (STAGES < 1) begin : g_bad_stages
    $error("logic_unit_pipe: STAGES must be >= 1");
  end

  logic [STAGES:0]          vld_pipe;
  logic [STAGES:0]          rdy_pipe;
  logic [STAGES:0][WIDTH:0] dat_pipe;
  logic [WIDTH-1:0]         res;

  always_comb begin
    res = '0;
    for (int j = 0; j < WIDTH; j++) res[j] = logic_op(in_a[j], in_b[j], in_op);
  end

  // Slot 0 of each array is the combinational input side; slot STAGES is the output side.
  assign vld_pipe[0]      = in_valid;
  assign dat_pipe[0]      = {~|res, res};
  assign rdy_pipe[STAGES] = out_ready;
  assign in_ready         = rdy_pipe[0];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    pipe_stage #(.W(WIDTH + 1)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (vld_pipe[i]),
      .up_ready (rdy_pipe[i]),
      .up_data  (dat_pipe[i]),
      .dn_valid (vld_pipe[i+1]),
      .dn_ready (rdy_pipe[i+1]),
      .dn_data  (dat_pipe[i+1])
    );
  end

  assign out_valid             = vld_pipe[STAGES];
  assign {out_zero, out_result} = dat_pipe[STAGES];
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench: a 32-bit/2-stage and an 8-bit/1-stage unit checked against an op-level model.
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  logic clk, rst;
  logic in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [31:0] in_a, in_b, out_result;
  logic [2:0]  in_op;
  logic in_valid8, in_ready8, out_valid8, out_ready8, out_zero8;
  logic [7:0] in_a8, in_b8, out_result8;
  logic [2:0] in_op8;

  logic_unit_pipe #(.WIDTH(32), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero));

  logic_unit_pipe #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_a(in_a8), .in_b(in_b8),
    .in_op(in_op8), .out_valid(out_valid8), .out_ready(out_ready8), .out_result(out_result8),
    .out_zero(out_zero8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        gen;
    logic [31:0] gres;
    logic        gz;
  } exp_t;

  exp_t q_a[$], q_b[$];
  exp_t e_a, e_b;
  int n_cmp = 0, n_bad = 0, acc_a = 0;
  logic g_en, g_z, rnd_on;
  logic [31:0] g_res;
  logic hold_a = 1'b0, hold_b = 1'b0, hz_a, hz_b;
  logic [31:0] hres_a, hres_b;
  logic [31:0] ops_gold [8];

  function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op, input int w);
    logic [31:0] r, m;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a ^ b);
      3'd4: r = a & ~b;
      3'd5: r = a | ~b;
      3'd6: r = ~(a & b);
      default: r = ~(a | b);
    endcase
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return r & m;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the 32-bit unit: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    if (rst) begin
      q_a.delete();
      hold_a = 1'b0;
    end else begin
      if (hold_a) begin
        cmp("a_hold_valid", 32'(out_valid), 32'd1);
        cmp("a_hold_result", out_result, hres_a);
        cmp("a_hold_zero", 32'(out_zero), 32'(hz_a));
      end
      if (out_valid && out_ready) begin
        if (q_a.size() == 0) cmp("a_unexpected_output", out_result, 32'hxxxx_xxxx);
        else begin
          e_a = q_a.pop_front();
          cmp("a_result", out_result, e_a.res);
          cmp("a_zero", 32'(out_zero), 32'(e_a.z));
          if (e_a.gen) begin
            cmp("a_gold_result", out_result, e_a.gres);
            cmp("a_gold_zero", 32'(out_zero), 32'(e_a.gz));
          end
        end
      end
      if (in_valid && in_ready) begin
        e_a.res = ref_op(in_a, in_b, in_op, 32);
        e_a.z = (e_a.res == 32'd0);
        e_a.gen = g_en; e_a.gres = g_res; e_a.gz = g_z;
        q_a.push_back(e_a);
        acc_a++;
      end
      hold_a = out_valid && !out_ready;
      hres_a = out_result;
      hz_a   = out_zero;
    end
  end

  // Same monitor for the 8-bit unit.
  always @(negedge clk) begin
    if (rst) begin
      q_b.delete();
      hold_b = 1'b0;
    end else begin
      if (hold_b) begin
        cmp("b_hold_valid", 32'(out_valid8), 32'd1);
        cmp("b_hold_result", {24'd0, out_result8}, hres_b);
        cmp("b_hold_zero", 32'(out_zero8), 32'(hz_b));
      end
      if (out_valid8 && out_ready8) begin
        if (q_b.size() == 0) cmp("b_unexpected_output", {24'd0, out_result8}, 32'hxxxx_xxxx);
        else begin
          e_b = q_b.pop_front();
          cmp("b_result", {24'd0, out_result8}, e_b.res);
          cmp("b_zero", 32'(out_zero8), 32'(e_b.z));
          if (e_b.gen) begin
            cmp("b_gold_result", {24'd0, out_result8}, e_b.gres);
            cmp("b_gold_zero", 32'(out_zero8), 32'(e_b.gz));
          end
        end
      end
      if (in_valid8 && in_ready8) begin
        e_b.res = ref_op({24'd0, in_a8}, {24'd0, in_b8}, in_op8, 8);
        e_b.z = (e_b.res == 32'd0);
        e_b.gen = g_en; e_b.gres = g_res; e_b.gz = g_z;
        q_b.push_back(e_b);
      end
      hold_b = out_valid8 && !out_ready8;
      hres_b = {24'd0, out_result8};
      hz_b   = out_zero8;
    end
  end

  // Random consumer backpressure while enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_on) begin
        out_ready  = 1'($urandom_range(0, 1));
        out_ready8 = 1'($urandom_range(0, 1));
      end
    end
  end

  // Presents one transaction to the selected unit and holds it until accepted.
  task automatic send(input int sel, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic gen, input logic [31:0] gres, input logic gz, output int waits);
    g_en = gen; g_res = gres; g_z = gz; waits = 0;
    if (sel == 0) begin in_valid = 1'b1; in_a = a; in_b = b; in_op = op; end
    else begin in_valid8 = 1'b1; in_a8 = a[7:0]; in_b8 = b[7:0]; in_op8 = op; end
    forever begin
      @(negedge clk);
      if ((sel == 0) ? in_ready : in_ready8) break;
      waits++;
      if (waits > 300) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: unit %0d never accepted, expected acceptance within 300 cycles", sel);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid8 = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 100 && (q_a.size() != 0 || q_b.size() != 0); t++) @(posedge clk);
    #1;
    cmp(name, 32'(q_a.size() + q_b.size()), 32'd0);
  endtask

  int w, w2, base;

  initial begin
    rst = 1'b1; rnd_on = 1'b0; out_ready = 1'b1; out_ready8 = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0; in_op8 = '0;
    g_en = 1'b0; g_res = '0; g_z = 1'b0;
    ops_gold = '{32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'hF00FF00F,
                 32'h00F000F0, 32'hF0FFF0FF, 32'h0FFF0FFF, 32'h000F000F};

    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("rst_in_ready_during", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    cmp("rst_out_valid", 32'(out_valid), 32'd0);
    cmp("rst_out_result", out_result, 32'd0);
    cmp("rst_out_zero", 32'(out_zero), 32'd0);
    cmp("rst_in_ready", 32'(in_ready), 32'd1);
    cmp("rst_out_valid8", 32'(out_valid8), 32'd0);
    @(posedge clk); #1;

    // Two-cycle latency on the 32-bit unit.
    send(0, 32'h1, 32'h2, OP_XOR, 1'b1, 32'h3, 1'b0, w);
    @(negedge clk); cmp("lat2_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk); cmp("lat2_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // Back-to-back with zero flag, no stall expected.
    send(0, 32'h2, 32'h2, OP_XOR, 1'b1, 32'h0, 1'b1, w); cmp("b2b_wait0", 32'(w), 32'd0);
    send(0, 32'h3, 32'h2, OP_XOR, 1'b1, 32'h1, 1'b0, w); cmp("b2b_wait1", 32'(w), 32'd0);

    for (int k = 0; k < 8; k++)
      send(0, 32'hF0F0F0F0, 32'hFF00FF00, 3'(k), 1'b1, ops_gold[k], 1'b0, w);
    repeat (4) @(posedge clk); #1;

    // Stalled consumer: only STAGES transactions fit.
    out_ready = 1'b0; base = acc_a;
    fork
      for (int k = 0; k < 4; k++) send(0, $urandom, $urandom, OP_OR, 1'b0, 32'd0, 1'b0, w2);
      begin
        repeat (6) @(negedge clk);
        cmp("bp_accepts", 32'(acc_a - base), 32'd2);
        cmp("bp_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain("bp_drained");
    cmp("bp_total_accepts", 32'(acc_a - base), 32'd4);

    // Reset with two transactions in flight.
    out_ready = 1'b0;
    send(0, $urandom, $urandom, OP_AND, 1'b0, 32'd0, 1'b0, w);
    send(0, $urandom, $urandom, OP_AND, 1'b0, 32'd0, 1'b0, w);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    cmp("midrst_out_valid", 32'(out_valid), 32'd0);
    cmp("midrst_out_result", out_result, 32'd0);
    cmp("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    send(0, 32'hFFFFFFFF, 32'h0000FFFF, OP_AND, 1'b1, 32'h0000FFFF, 1'b0, w);
    @(negedge clk); cmp("postrst_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk); cmp("postrst_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // Random traffic, 32-bit unit.
    rnd_on = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send(0, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'b0, 32'd0, 1'b0, w);
    end
    rnd_on = 1'b0; out_ready = 1'b1; out_ready8 = 1'b1;
    drain("a_final_empty");
    @(posedge clk); #1;

    // 8-bit, single-stage unit.
    send(1, 32'h0F, 32'hF0, OP_NOR, 1'b1, 32'h00, 1'b1, w);
    @(negedge clk); cmp("lat1_valid", 32'(out_valid8), 32'd1);
    @(posedge clk); #1;
    rnd_on = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send(1, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'b0, 32'd0, 1'b0, w);
    end
    rnd_on = 1'b0; out_ready = 1'b1; out_ready8 = 1'b1;
    drain("b_final_empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
